// File: rtl/alu_pkg.sv
// Shared ALU encodings and the DIV/MOD sequencer state type.
// Used by alu_divmod_sequencer and the control unit's ALUControl decode.
package alu_pkg;

    localparam logic [2:0] ALU_DIV = 3'b100;
    localparam logic [2:0] ALU_MOD = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FINISH
    } divmod_state_t;

    function automatic logic is_divmod(input logic [2:0] ctrl);
        return (ctrl == ALU_DIV) || (ctrl == ALU_MOD);
    endfunction

endpackage

// File: rtl/alu_div_step.sv
// One restoring shift-subtract division step: shifts the next dividend bit into the
// partial remainder and subtracts the divisor when it fits.
module alu_div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0]   partial;
    logic [WIDTH-1:0] diff;
    logic             fits;

    always_comb begin
        // Extra top bit keeps the compare exact when rem has its MSB set.
        partial = {rem, quo[WIDTH-1]};
        fits    = partial >= {1'b0, divisor};
        // When fits, the true difference is below divisor, so WIDTH bits suffice.
        diff    = partial[WIDTH-1:0] - divisor;
        if (fits) begin
            rem_next = diff;
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = partial[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/alu_divmod_sequencer.sv
// Multi-cycle DIV/MOD sequencer: one quotient bit per cycle, stalls the pipe meanwhile.
// Define DIVMOD_SIGNED_EN for two's-complement operands; default build is unsigned.
module alu_divmod_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       alu_control,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             div_zero
);

    localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    divmod_state_t    state;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] divisor_q;
    logic [CNT_W-1:0] count_q;
    logic             is_mod_q;

    logic             accept;
    logic [WIDTH-1:0] dividend_in;
    logic [WIDTH-1:0] divisor_in;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quo_step;
    logic [WIDTH-1:0] quo_final;
    logic [WIDTH-1:0] rem_final;

    always_comb begin
        accept = (state == IDLE) && start && is_divmod(alu_control);
        stall  = accept || (state == CALC);
    end

`ifdef DIVMOD_SIGNED_EN
    logic quo_neg_q;
    logic rem_neg_q;

    // The most-negative value maps onto itself, which is its correct unsigned magnitude.
    always_comb begin
        dividend_in = op_a[WIDTH-1] ? (~op_a + 1'b1) : op_a;
        divisor_in  = op_b[WIDTH-1] ? (~op_b + 1'b1) : op_b;
        quo_final   = quo_neg_q ? (~quo_step + 1'b1) : quo_step;
        rem_final   = rem_neg_q ? (~rem_step + 1'b1) : rem_step;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
        end else if (accept) begin
            quo_neg_q <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
            rem_neg_q <= op_a[WIDTH-1];
        end
    end
`else
    always_comb begin
        dividend_in = op_a;
        divisor_in  = op_b;
        quo_final   = quo_step;
        rem_final   = rem_step;
    end
`endif

    alu_div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem     (rem_q),
        .quo     (quo_q),
        .divisor (divisor_q),
        .rem_next(rem_step),
        .quo_next(quo_step)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            count_q   <= '0;
            is_mod_q  <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            div_zero  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        quo_q     <= dividend_in;
                        divisor_q <= divisor_in;
                        rem_q     <= '0;
                        count_q   <= CNT_W'(WIDTH - 1);
                        is_mod_q  <= (alu_control == ALU_MOD);
                        if (op_b == '0) begin
                            // Zero divisor skips CALC and bypasses sign correction.
                            state    <= FINISH;
                            done     <= 1'b1;
                            div_zero <= 1'b1;
                            result   <= (alu_control == ALU_MOD) ? op_a : '1;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_q <= rem_step;
                    quo_q <= quo_step;
                    if (count_q == '0) begin
                        state    <= FINISH;
                        done     <= 1'b1;
                        div_zero <= 1'b0;
                        result   <= is_mod_q ? rem_final : quo_final;
                    end else begin
                        count_q <= count_q - 1'b1;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/alu_divmod_sequencer.md
# alu_divmod_sequencer

Multi-cycle sequencer for the DIV (ALUControl 3'b100) and MOD (3'b101) operations of the processor's ALU path. It accepts a request from the execute stage, runs a restoring shift-subtract division one quotient bit per cycle, and holds the pipeline with `stall` until the result is ready. Single-cycle ALU operations bypass this block entirely; its `result` is muxed into the ALU result path when `done` is high.

## Interface
- `WIDTH`, default 32: operand and result width in bits.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request from execute stage; valid only together with `alu_control` 3'b100/3'b101.
- `alu_control`  in  3  operation select; 3'b100 = quotient, 3'b101 = remainder; other codes never start the block.
- `op_a`  in  WIDTH  dividend.
- `op_b`  in  WIDTH  divisor.
- `stall`  out  1  pipeline hold request.
- `done`  out  1  one-cycle pulse; `result` is valid in this cycle.
- `result`  out  WIDTH  quotient or remainder, held until the next accepted start.
- `div_zero`  out  1  set with `done` when `op_b` was 0; held with `result`.

## Operation
- States: IDLE, CALC, FINISH.
- IDLE: request accepted when `start`=1 and `alu_control` is 3'b100 or 3'b101. On the accepting edge, latch operands, operation and sign information. Clear the remainder register. Load the bit counter with WIDTH-1.
- Accepted with `op_b`=0: go directly to FINISH. The result is all-ones for DIV and `op_a` for MOD. `div_zero`=1.
- Otherwise go to CALC.
- CALC, one step per cycle:
  - rem' = {rem[WIDTH-2:0], quo[WIDTH-1]}
  - quo shifts left by one bit.
  - If rem' ≥ divisor: rem' -= divisor and quo[0]=1.
  - Both registers are WIDTH bits. The comparison uses WIDTH+1 bits so there is no overflow.
  - The counter decrements. When the counter is 0 and the step has executed, go to FINISH.
- FINISH: `done`=1 and `result` is updated (quotient for DIV, remainder for MOD). Return to IDLE on the next edge.
- `start` while in CALC or FINISH is ignored. No queueing. The requester re-presents the request after `done`.
- `start` with any other `alu_control` value: no effect, `stall` stays 0.
- Reset, including mid-operation: state IDLE, `stall`=0, `done`=0, `result`=0, `div_zero`=0, counter=0, internal registers 0.

## Timing
- `stall` is combinational:
  - (IDLE and accepted request), or
  - CALC.
- `stall` is 0 in FINISH, so the pipeline advances in the same cycle that it captures `result`.
- Latency, counted with the accepting edge as edge 0:
  - Non-zero divisor: CALC occupies cycles 1..WIDTH, FINISH is cycle WIDTH+1.
  - Zero divisor: FINISH is cycle 1.
- Back-to-back requests: a new start is accepted at the earliest in the cycle after FINISH (IDLE).
- `result` and `div_zero` change only on the transition into FINISH and hold otherwise.

## Configuration
- `DIVMOD_SIGNED_EN` defined: operands are two's complement.
  - On acceptance, latch the absolute values of both operands.
  - In FINISH, negate the quotient if the operand signs differ, and negate the remainder if `op_a` was negative.
  - op_a = most-negative and op_b = -1: quotient = op_a, remainder = 0, normal CALC latency.
  - Zero divisor behaves as in Operation and is not sign-corrected.
- Not defined: operands are unsigned and the sign-handling logic is absent.

## Structure
- Package `alu_pkg`:
  - constants `ALU_DIV`=3'b100 and `ALU_MOD`=3'b101, shared with the control unit's ALUControl encoding;
  - state enum `divmod_state_t` {IDLE, CALC, FINISH}.
- Sub-module `alu_div_step`: combinational single restoring step. Inputs are rem, quo and divisor; outputs are rem', quo'. Instantiated once, fed from the registers.

## Test plan
- DIV 100 / 7, unsigned, WIDTH=32 → `stall` high for 33 cycles including the accept cycle; `done` at cycle 33; `result`=14; `div_zero`=0.
- MOD 100 / 7 → `result`=2 at cycle 33. Then DIV 0xFFFFFFFF / 1 → `result`=0xFFFFFFFF.
- DIV 5 / 0 → `done` at cycle 1, `result`=0xFFFFFFFF, `div_zero`=1. MOD 5 / 0 → `result`=5, `div_zero`=1.
- Second `start` pulsed at cycle 10 of a DIV, and `start` with `alu_control`=3'b000 in IDLE → both ignored; one `done` only; `stall` stays 0 for the 3'b000 request.
- `rst` asserted at cycle 15 of CALC → immediately `stall`=0, `result`=0, state IDLE. A fresh DIV 9/3 afterwards → `result`=3.
- With `DIVMOD_SIGNED_EN`:
  - -7 / 2 → quotient -3 (0xFFFFFFFD); remainder -1.
  - 0x80000000 / -1 → quotient 0x80000000, remainder 0.
